hemaia_multi_clock_divider: RTL

Multi-channel integer clock divider for the HeMAiA clock/reset controller. From one source clock it produces `NumChannels` independently divided clocks. Each channel has a run-time divisor loaded through a valid/ready handshake, glitch-free enable gating, and a 50 % duty cycle for both odd and even divisors. A shared `sync_i` strobe phase-aligns all channels, so related domains (core, cluster, D2D link) can be restarted on a common edge.

---
 rtl/hemaia_clk_div_pkg.sv | 16 +
 rtl/hemaia_clock_div_channel.sv | 127 ++++++++++++
 rtl/hemaia_multi_clock_divider.sv | 38 +++
 3 files changed

// File: rtl/hemaia_clk_div_pkg.sv
// Shared types and constants for the HeMAiA multi-channel clock divider.
package hemaia_clk_div_pkg;

    localparam int unsigned DivWidth = 4;

    typedef logic [DivWidth-1:0] divisor_t;

    localparam int unsigned DivStop   = 0;
    localparam int unsigned DivBypass = 1;

    typedef enum logic {
        ChIdle,
        ChRun
    } chan_state_e;

endpackage

// File: rtl/hemaia_clock_div_channel.sv
// One divided-clock channel: counter, divisor handshake, enable gating,
// posedge/negedge waveform flops and the glitch-free output mux.
(* keep_hierarchy = "yes", no_ungroup = "true", no_boundary_optimization = "true" *)
module hemaia_clock_div_channel
    import hemaia_clk_div_pkg::*;
#(
    parameter int unsigned Width           = DivWidth,
    parameter int unsigned DefaultDivision = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [Width-1:0] divisor_i,
    input  logic             divisor_valid_i,
    output logic             divisor_ready_o,
    input  logic             enable_i,
    input  logic             sync_i,
    output logic [Width-1:0] divisor_o,
    output logic             clk_o
);

    chan_state_e      state_q, state_d;
    logic [Width-1:0] cnt_q, cnt_d;
    logic [Width-1:0] div_q, div_d;
    logic [Width-1:0] pendDiv_q, pendDiv_d;
    logic             pend_q, pend_d;
    logic             r1_q, r2_q, bypass_q;

    logic             stopped;
    logic             boundary;
    logic             accept;
    logic             applyNow;
    logic             rawClk;
    logic [Width-1:0] lastCnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ChIdle;
            cnt_q     <= '0;
            div_q     <= Width'(DefaultDivision);
            pendDiv_q <= '0;
            pend_q    <= 1'b0;
            r1_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            pendDiv_q <= pendDiv_d;
            pend_q    <= pend_d;
            r1_q      <= rawClk;
        end
    end

    // Select flops live on the falling edge so the output mux only switches while clk_i is low.
    always_ff @(negedge clk_i) begin
        if (rst_i) begin
            r2_q     <= 1'b0;
            bypass_q <= 1'b0;
        end else begin
            r2_q     <= r1_q;
            bypass_q <= (state_q == ChRun) && (div_q == Width'(DivBypass));
        end
    end

    always_comb begin
        stopped  = (div_q == Width'(DivStop));
        lastCnt  = stopped ? '0 : div_q - Width'(1);
        boundary = (state_q == ChRun) && !stopped && (cnt_q == lastCnt);
        accept   = divisor_valid_i && !pend_q;

        state_d   = state_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        pend_d    = pend_q;
        pendDiv_d = pendDiv_q;
        applyNow  = 1'b0;

        if (accept) begin
            pend_d    = 1'b1;
            pendDiv_d = divisor_i;
        end

        // Sync outranks the boundary so a pending divisor always lands on the common restart.
        case (state_q)
            ChIdle: begin
                cnt_d    = '0;
                applyNow = pend_q;
                if (enable_i) begin
                    state_d = ChRun;
                end
            end
            ChRun: begin
                if (stopped) begin
                    cnt_d    = '0;
                    applyNow = pend_q;
                    if (!enable_i) begin
                        state_d = ChIdle;
                    end
                end else if (sync_i) begin
                    cnt_d    = '0;
                    applyNow = pend_q;
                end else if (boundary) begin
                    cnt_d    = '0;
                    applyNow = pend_q;
                    if (!enable_i) begin
                        state_d = ChIdle;
                    end
                end else begin
                    cnt_d = cnt_q + Width'(1);
                end
            end
            default: state_d = ChIdle;
        endcase

        if (applyNow) begin
            div_d  = pendDiv_q;
            pend_d = 1'b0;
        end

        rawClk = (state_q == ChRun) && !stopped && (div_q != Width'(DivBypass))
                 && (cnt_q >= (div_q >> 1));
    end

    assign divisor_ready_o = !pend_q;
    assign divisor_o       = div_q;
    assign clk_o           = bypass_q ? clk_i : (div_q[0] ? (r1_q & r2_q) : r1_q);

endmodule

// File: rtl/hemaia_multi_clock_divider.sv
// Multi-channel integer clock divider: NumChannels independent dividers
// sharing one source clock and a common sync strobe.
module hemaia_multi_clock_divider
    import hemaia_clk_div_pkg::*;
#(
    parameter int unsigned NumChannels      = 4,
    parameter int unsigned MaxDivisionWidth = DivWidth,
    parameter int unsigned DefaultDivision  = 1
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [NumChannels*MaxDivisionWidth-1:0] divisor_i,
    input  logic [NumChannels-1:0]                divisor_valid_i,
    output logic [NumChannels-1:0]                divisor_ready_o,
    input  logic [NumChannels-1:0]                enable_i,
    input  logic                                  sync_i,
    output logic [NumChannels*MaxDivisionWidth-1:0] divisor_o,
    output logic [NumChannels-1:0]                clk_o
);

    for (genvar ch = 0; ch < NumChannels; ch++) begin : gen_channel
        hemaia_clock_div_channel #(
            .Width          (MaxDivisionWidth),
            .DefaultDivision(DefaultDivision)
        ) u_channel (
            .clk_i          (clk_i),
            .rst_i          (rst_i),
            .divisor_i      (divisor_i[ch*MaxDivisionWidth +: MaxDivisionWidth]),
            .divisor_valid_i(divisor_valid_i[ch]),
            .divisor_ready_o(divisor_ready_o[ch]),
            .enable_i       (enable_i[ch]),
            .sync_i         (sync_i),
            .divisor_o      (divisor_o[ch*MaxDivisionWidth +: MaxDivisionWidth]),
            .clk_o          (clk_o[ch])
        );
    end

endmodule
